// File: rtl/wrr_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wrr_packet_arbiter
// Brief    : Weighted round-robin arbiter. The grant is registered, one-hot and
//            held for a whole packet, or for one beat when PKT_MODE=0.
//            Define WRR_WEIGHTS_EN to enable per-channel weights (credit counter).
// Revision : 1.0  initial release
// ============================================================================
module wrr_packet_arbiter #(
    parameter int N        = 4,
    parameter int WW       = 4,
    parameter int PKT_MODE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [N-1:0]         req,
    input  logic [N*WW-1:0]      weights,
    input  logic                 beat_valid,
    input  logic                 beat_last,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IW = $clog2(N);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [N-1:0]  r_grant, w_grant_nxt, w_onehot;
    logic          r_grant_valid;
    logic [IW-1:0] r_idx, w_idx_nxt;
    logic [IW-1:0] r_last_idx, w_last_nxt;
    logic [IW-1:0] w_base, w_win_idx;
    logic          w_win_found;
    logic          w_unit_end;
    logic          w_keep;
    logic          w_load;
    logic          w_consume;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
        int t;
        t = int'(base) + k;
        if (t >= N) t = t - N;
        return t[IW-1:0];
    endfunction

    // At a turn end the search starts after the channel that just finished.
    assign w_base = (r_state == S_BUSY) ? r_idx : r_last_idx;

    always_comb begin : p_winner
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!w_win_found && req[wrap_add(w_base, k)]) begin
                w_win_found = 1'b1;
                w_win_idx   = wrap_add(w_base, k);
            end
        end
    end

    assign w_onehot   = {{(N-1){1'b0}}, 1'b1} << w_win_idx;
    assign w_unit_end = beat_valid & (beat_last | (PKT_MODE == 0));

`ifdef WRR_WEIGHTS_EN
    localparam logic [WW:0] C_CREDIT_ONE = {{WW{1'b0}}, 1'b1};

    logic [WW:0]   r_credit, w_credit_dec, w_win_credit;
    logic [WW-1:0] w_win_weight;

    assign w_win_weight = weights[int'(w_win_idx)*WW +: WW];
    assign w_win_credit = (w_win_weight == '0) ? C_CREDIT_ONE : {1'b0, w_win_weight};
    assign w_credit_dec = (r_credit == '0) ? '0 : (r_credit - C_CREDIT_ONE);
    assign w_keep       = (w_credit_dec != '0) & req[r_idx];

    always_ff @(posedge clk or posedge rst) begin : p_credit
        if (rst) begin
            r_credit <= '0;
        end else if (w_load) begin
            r_credit <= w_win_credit;
        end else if (w_consume) begin
            r_credit <= w_credit_dec;
        end
    end
`else
    // Every channel effectively has weight 1: each turn is exactly one unit.
    logic w_unused_sigs;
    assign w_unused_sigs = ^{weights, w_load, w_consume};
    assign w_keep        = 1'b0;
`endif

    always_comb begin : p_next
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last_idx;
        w_load      = 1'b0;
        w_consume   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && w_win_found) begin
                    w_state_nxt = S_BUSY;
                    w_grant_nxt = w_onehot;
                    w_idx_nxt   = w_win_idx;
                    w_load      = 1'b1;
                end
            end
            S_BUSY: begin
                if (w_unit_end) begin
                    w_consume = 1'b1;
                    if (!w_keep) begin
                        w_last_nxt = r_idx;
                        if (enable && w_win_found) begin
                            w_grant_nxt = w_onehot;
                            w_idx_nxt   = w_win_idx;
                            w_load      = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_grant_nxt = '0;
                            w_idx_nxt   = '0;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin : p_regs
        if (rst) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_idx         <= '0;
            r_last_idx    <= IW'(N - 1);
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_valid <= |w_grant_nxt;
            r_idx         <= w_idx_nxt;
            r_last_idx    <= w_last_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign grant_idx   = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_wrr_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wrr_packet_arbiter
// Brief    : Self-checking bench for wrr_packet_arbiter, packet mode and beat
//            mode instances side by side against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_wrr_packet_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;

    logic                 clk;
    logic                 rst;
    logic                 enable;
    logic [N-1:0]         req;
    logic [N*WW-1:0]      weights;
    logic                 beat_valid;
    logic                 beat_last;
    logic [N-1:0]         g  [2];
    logic                 gv [2];
    logic [$clog2(N)-1:0] gi [2];

    int checks = 0;
    int errors = 0;

    // Model state per instance: owner (-1 = idle), last winner, remaining credit.
    int own  [2];
    int last [2];
    int cred [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wrr_packet_arbiter #(.N(N), .WW(WW), .PKT_MODE(1)) u_dut_pkt (
        .clk(clk), .rst(rst), .enable(enable), .req(req), .weights(weights),
        .beat_valid(beat_valid), .beat_last(beat_last),
        .grant(g[0]), .grant_valid(gv[0]), .grant_idx(gi[0])
    );

    wrr_packet_arbiter #(.N(N), .WW(WW), .PKT_MODE(0)) u_dut_beat (
        .clk(clk), .rst(rst), .enable(enable), .req(req), .weights(weights),
        .beat_valid(beat_valid), .beat_last(beat_last),
        .grant(g[1]), .grant_valid(gv[1]), .grant_idx(gi[1])
    );

    function automatic int wt(input int ch);
        int w;
        w = int'(weights[ch*WW +: WW]);
        if (w == 0) w = 1;
`ifndef WRR_WEIGHTS_EN
        w = 1;
`endif
        return w;
    endfunction

    function automatic int pick(input int base);
        for (int k = 1; k <= N; k++) begin
            if (req[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    function automatic void mreset();
        for (int m = 0; m < 2; m++) begin
            own[m]  = -1;
            last[m] = N - 1;
            cred[m] = 0;
        end
    endfunction

    function automatic void mstep(input int m);
        bit ue;
        ue = beat_valid && (beat_last || (m == 1));
        if (own[m] < 0) begin
            if (enable && req != 0) begin
                own[m]  = pick(last[m]);
                cred[m] = wt(own[m]);
            end
        end else if (ue) begin
            if (cred[m] > 0) cred[m]--;
            if (cred[m] == 0 || !req[own[m]]) begin
                last[m] = own[m];
                if (enable && req != 0) begin
                    own[m]  = pick(last[m]);
                    cred[m] = wt(own[m]);
                end else begin
                    own[m] = -1;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] eg;
        for (int m = 0; m < 2; m++) begin
            eg = '0;
            if (own[m] >= 0) eg[own[m]] = 1'b1;
            chk($sformatf("%s.m%0d.grant", tag, m), 32'(g[m]), 32'(eg));
            chk($sformatf("%s.m%0d.valid", tag, m), 32'(gv[m]), 32'(own[m] >= 0));
            chk($sformatf("%s.m%0d.idx", tag, m), 32'(gi[m]), (own[m] < 0) ? 32'd0 : 32'(own[m]));
        end
    endtask

    task automatic step(input string tag);
        mstep(0);
        mstep(1);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        req        = '0;
        weights    = '0;
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        mreset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Fair rotation with single-beat packets
        weights    = {N{4'h1}};
        enable     = 1'b1;
        req        = 4'b1111;
        beat_valid = 1'b1;
        beat_last  = 1'b1;
        step("fair");
        chk("fair.first", 32'(g[0]), 32'b0001);
        repeat (5) step("fair");

        // Weighted: ch0=3, ch1=1
        weights = 16'h0013;
        req     = 4'b0011;
        repeat (10) step("wrr");

        // Packet lock on ch2
        req = '0;
        repeat (5) step("drain");
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        req        = 4'b0100;
        step("lock.grant");
        chk("lock.grant.lit", 32'(g[0]), 32'b0100);
        beat_valid = 1'b1;
        step("lock.b1");
        req = 4'b1011;
        step("lock.b2");
        step("lock.b3");
        chk("lock.hold.lit", 32'(g[0]), 32'b0100);
        beat_last = 1'b1;
        step("lock.b4");
        chk("lock.next.lit", 32'(g[0]), 32'b1000);

        // Enable drop: beat-mode instance releases at the next beat
        req = '0;
        repeat (3) step("drain2");
        req        = 4'b0101;
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        step("en.grant");
        enable = 1'b0;
        repeat (2) step("en.hold");
        beat_valid = 1'b1;
        step("en.release");
        chk("en.release.lit", 32'(g[1]), 32'b0000);
        repeat (3) step("en.idle");
        enable = 1'b1;
        step("en.back");

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            req        = 4'($urandom);
            enable     = ($urandom_range(0, 7) != 0);
            beat_valid = ($urandom_range(0, 2) != 0);
            beat_last  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) weights = 16'($urandom);
            step("rand");
        end

        // Asynchronous reset mid-packet
        enable     = 1'b1;
        beat_valid = 1'b1;
        beat_last  = 1'b1;
        req        = '0;
        repeat (3) step("drain3");
        req        = 4'b0100;
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        step("rst.grant");
        chk("rst.grant.lit", 32'(g[0]), 32'b0100);
        beat_valid = 1'b1;
        step("rst.mid");
        #2;
        rst = 1'b1;
        #1;
        mreset();
        check_all("rst.async");
        chk("rst.async.lit", 32'(g[0]), 32'b0000);
        @(negedge clk);
        rst        = 1'b0;
        req        = 4'b1111;
        beat_valid = 1'b0;
        step("rst.after");
        chk("rst.after.lit", 32'(g[0]), 32'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wrr_packet_arbiter.md
# wrr_packet_arbiter

Parametrised weighted round-robin arbiter for the AXIS switch, replacing the single-cycle rotating arbiter on the switch input side. It arbitrates N stream requesters and holds the grant for whole packets, or for single beats in beat mode. Each channel gets a programmable number of consecutive packets (its weight) per turn. The grant is registered, one-hot and bubble-free: the next winner is chosen in the same cycle the current turn ends.

## Interface
- N, 4: number of requesters; must be at least 2.
- WW, 4: width of each per-channel weight field.
- PKT_MODE, 1: 1 = grant locked until the end of a packet (`beat_last`); 0 = every beat is one arbitration unit.

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  allows new grants to be issued; an in-flight turn always completes
- req  in  N  request per channel
- weights  in  N*WW  per-channel weight, channel i at [i*WW +: WW]; value 0 is treated as 1; sampled when channel i wins
- beat_valid  in  1  handshake (tvalid & tready) of the currently granted stream
- beat_last  in  1  tlast of that beat; ignored when PKT_MODE=0
- grant  out  N  registered one-hot grant
- grant_valid  out  1  equals |grant
- grant_idx  out  $clog2(N)  binary index of the granted channel; 0 when idle

## Operation
- State machine has two states, IDLE and BUSY.
- IDLE: grant=0. If enable & |req, the rotating-priority winner is registered into grant, credit is loaded with weight(winner), and the state moves to BUSY.
- Priority is rotating: the search starts at last_idx+1 modulo N. After reset, last_idx=N-1, so channel 0 has highest priority.
- Unit end is `beat_valid & beat_last` when PKT_MODE=1, and `beat_valid` when PKT_MODE=0.
- Credit behaviour in BUSY:
  - On each unit end, credit decrements by 1.
  - The turn continues, with grant unchanged, if the decremented credit is nonzero and req[cur] is high.
  - Otherwise the turn ends. last_idx becomes cur and arbitration runs in that same cycle.
- At turn end: if enable & |req, the new winner is registered with no idle cycle between grants and its weight is loaded into credit. The previous owner may win again only if it is the sole requester. If there is no request or enable is low, the state returns to IDLE with grant=0.
- Packet lock: while in BUSY, changes to req (including req[cur] dropping mid-packet) and to weights do not alter grant until the unit end.
- beat_valid while IDLE is ignored.
- credit is WW+1 bits wide. It saturates at 0 and never wraps.

## Timing
- Reset values: grant=0, grant_valid=0, grant_idx=0, state=IDLE, credit=0, last_idx=N-1. rst clears all of these immediately, independent of clk, including mid-packet.
- req to grant: 1 cycle (req sampled at edge k, grant visible after edge k).
- Turn end to next grant: the new grant is visible after the same edge that samples the final beat.
- grant_idx and grant_valid are registered together with grant; they never disagree with grant.
- Simultaneous events:
  - A unit end coinciding with enable falling causes release to IDLE.
  - A unit end coinciding with a new req from a higher-priority channel lets that req participate in the arbitration.

## Configuration
- WRR_WEIGHTS_EN defined: per-channel weights operate as described above.
- WRR_WEIGHTS_EN undefined: the weights port is present but ignored. Every channel has weight 1, so each turn is exactly one unit (plain round robin with packet lock). The credit counter is not synthesised.

## Test plan
- Reset: assert rst mid-packet with grant=0100 -> grant=0000, grant_idx=0 and grant_valid=0 without waiting for a clk edge. After release, req=1111 -> first grant=0001.
- Fair rotation: weights all 1, PKT_MODE=1, req=1111, single-beat packets (beat_valid=beat_last=1) every cycle -> grant sequence 0001, 0010, 0100, 1000, 0001, with no idle cycles.
- Weighting (macro defined): weights ch0=3, ch1=1, req=0011 held, single-beat packets -> per-packet grant order 0,0,0,1,0,0,0,1.
- Packet lock: ch2 granted; req2 drops after beat 1 of a 4-beat packet; req=1011 stays high on the other channels -> grant stays 0100 through beat 4 (last), then becomes 1000 after the next edge.
- Beat mode and enable: PKT_MODE=0, req=0101, enable dropped while ch0 is granted -> ch0 keeps the grant until the next beat_valid, then grant=0000 and stays 0 until enable returns.
- Macro undefined: weights ch0=3, ch1=1, req=0011 -> per-packet grant order alternates 0,1,0,1.
